ni_payload_serializer: RTL and testbench

Parametrised, sequential flit serializer for the NI resend path. It captures a response payload of up to MAX_FLITS flit bodies and emits them one chunk per cycle over a valid/ready handshake, marking the last chunk. It retains the payload after sending so it can be replayed on a resend request. It sits between the NI response packetiser and the flit-type/header insertion stage, ahead of the NoC output buffer.

---
 rtl/ni_payload_serializer_pkg.sv | 22 ++
 rtl/ni_flit_chunk_mux.sv | 27 ++
 rtl/ni_payload_serializer.sv | 116 +++++++++++
 tb/tb_ni_payload_serializer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/ni_payload_serializer_pkg.sv
// Shared NI/NoC parameters, serializer state encoding and a constant clog2 helper.
package ni_payload_serializer_pkg;

    localparam int FTYPEWD       = 2;
    localparam int COUNTERFLITWD = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_HOLD = 2'd2
    } ser_state_e;

    function automatic int ni_clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/ni_flit_chunk_mux.sv
// Combinational selector returning chunk idx_i of a flat payload; out-of-range indices give zero.
module ni_flit_chunk_mux #(
    parameter int BASE_WIDTH = 30,
    parameter int MAX_FLITS  = 4,
    parameter int CNT_WD     = 3
) (
    input  logic [BASE_WIDTH*MAX_FLITS-1:0] payload_i,
    input  logic [CNT_WD-1:0]               idx_i,
    output logic [BASE_WIDTH-1:0]           chunk_o
);

    logic [BASE_WIDTH-1:0] chunks [MAX_FLITS];

    for (genvar gi = 0; gi < MAX_FLITS; gi++) begin : g_chunk
        assign chunks[gi] = payload_i[gi*BASE_WIDTH +: BASE_WIDTH];
    end

    always_comb begin
        chunk_o = '0;
        for (int k = 0; k < MAX_FLITS; k++) begin
            if (idx_i == CNT_WD'(k)) begin
                chunk_o = chunks[k];
            end
        end
    end

endmodule

// File: rtl/ni_payload_serializer.sv
// Captures a multi-flit response payload and emits it chunk by chunk over valid/ready,
// retaining it afterwards so a resend request can replay it from chunk 0.
module ni_payload_serializer
    import ni_payload_serializer_pkg::*;
#(
    parameter int FLIT_WIDTH    = 32,
    parameter int FTYPE_WD      = FTYPEWD,
    parameter int BASE_WIDTH    = FLIT_WIDTH - FTYPE_WD,
    parameter int MAX_FLITS     = 4,
    parameter int PAYLOAD_WIDTH = BASE_WIDTH * MAX_FLITS,
    parameter int CNT_WD        = ni_clog2(MAX_FLITS + 1)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     load_valid,
    output logic                     load_ready,
    input  logic [PAYLOAD_WIDTH-1:0] load_payload,
    input  logic [CNT_WD-1:0]        load_nflits,
    input  logic                     resend,
    output logic                     flit_valid,
    input  logic                     flit_ready,
    output logic [BASE_WIDTH-1:0]    flit_data,
    output logic                     flit_last,
    output logic [CNT_WD-1:0]        flit_index,
    output logic                     busy
);

    ser_state_e               state_q, state_d;
    logic [CNT_WD-1:0]        idx_q, idx_d;
    logic [CNT_WD-1:0]        nflits_q, nflits_d;
    logic [PAYLOAD_WIDTH-1:0] payload_q, payload_d;
    logic [BASE_WIDTH-1:0]    flit_data_q;
    logic [BASE_WIDTH-1:0]    chunk_d;
    logic [CNT_WD-1:0]        nflits_clamped;
    logic                     load_acc;
    logic                     handshake;
    logic                     last_chunk;

    assign load_ready     = (state_q != ST_SEND) && !reset;
    assign load_acc       = load_valid && load_ready;
    assign flit_valid     = (state_q == ST_SEND);
    assign handshake      = flit_valid && flit_ready;
    assign last_chunk     = (idx_q == nflits_q - CNT_WD'(1));
    assign nflits_clamped = (load_nflits > CNT_WD'(MAX_FLITS)) ? CNT_WD'(MAX_FLITS) : load_nflits;

    assign flit_data  = flit_data_q;
    assign flit_last  = last_chunk && flit_valid;
    assign flit_index = idx_q;
    assign busy       = (state_q == ST_SEND);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        nflits_d  = nflits_q;
        payload_d = payload_q;
        unique case (state_q)
            ST_IDLE, ST_HOLD: begin
                // An accepted load always beats a concurrent resend, even a zero-length one.
                if (load_acc) begin
                    if (load_nflits != '0) begin
                        payload_d = load_payload;
                        nflits_d  = nflits_clamped;
                        idx_d     = '0;
                        state_d   = ST_SEND;
                    end
                end else if (state_q == ST_HOLD && resend) begin
                    idx_d   = '0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (resend) begin
                    idx_d = '0;
                end else if (handshake) begin
                    if (last_chunk) begin
                        idx_d   = '0;
                        state_d = ST_HOLD;
                    end else begin
                        idx_d = idx_q + CNT_WD'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    ni_flit_chunk_mux #(
        .BASE_WIDTH (BASE_WIDTH),
        .MAX_FLITS  (MAX_FLITS),
        .CNT_WD     (CNT_WD)
    ) u_chunk_mux (
        .payload_i (payload_d),
        .idx_i     (idx_d),
        .chunk_o   (chunk_d)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            nflits_q    <= '0;
            payload_q   <= '0;
            flit_data_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            nflits_q    <= nflits_d;
            payload_q   <= payload_d;
            flit_data_q <= (state_d == ST_SEND) ? chunk_d : '0;
        end
    end

endmodule

// File: tb/tb_ni_payload_serializer.sv
// Directed bench for ni_payload_serializer: load, stall, resend, clamp and reset scenarios.
module tb_ni_payload_serializer;

    localparam int BW  = 30;
    localparam int MF  = 4;
    localparam int PW  = BW * MF;
    localparam int CW  = 3;

    logic          clock = 1'b0;
    logic          reset;
    logic          load_valid;
    logic          load_ready;
    logic [PW-1:0] load_payload;
    logic [CW-1:0] load_nflits;
    logic          resend;
    logic          flit_valid;
    logic          flit_ready;
    logic [BW-1:0] flit_data;
    logic          flit_last;
    logic [CW-1:0] flit_index;
    logic          busy;

    int checks = 0;
    int errors = 0;

    logic [BW-1:0] abcd [4];
    logic [PW-1:0] abcd_payload;

    ni_payload_serializer dut (
        .clock        (clock),
        .reset        (reset),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .load_payload (load_payload),
        .load_nflits  (load_nflits),
        .resend       (resend),
        .flit_valid   (flit_valid),
        .flit_ready   (flit_ready),
        .flit_data    (flit_data),
        .flit_last    (flit_last),
        .flit_index   (flit_index),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Offers one payload for a single cycle (stimulus only).
    task automatic do_load(input logic [PW-1:0] p, input logic [CW-1:0] n);
        load_valid   = 1'b1;
        load_payload = p;
        load_nflits  = n;
        tick();
        load_valid   = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++; if (flit_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", flit_valid); end
        checks++; if (flit_data !== '0) begin errors++; $display("FAIL reset_data got %h want 0", flit_data); end
        checks++; if (flit_last !== 1'b0) begin errors++; $display("FAIL reset_last got %b want 0", flit_last); end
        checks++; if (flit_index !== '0) begin errors++; $display("FAIL reset_index got %0d want 0", flit_index); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL reset_load_ready got %b want 0", load_ready); end
        reset = 1'b0;
        #1;
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL idle_load_ready got %b want 1", load_ready); end
        $display("reset: checked reset values");
    endtask

    task automatic test_basic();
        flit_ready = 1'b1;
        do_load(abcd_payload, 3'd4);
        for (int k = 0; k < 4; k++) begin
            checks++; if (flit_valid !== 1'b1) begin errors++; $display("FAIL basic_valid[%0d] got %b want 1", k, flit_valid); end
            checks++; if (flit_data !== abcd[k]) begin errors++; $display("FAIL basic_data[%0d] got %h want %h", k, flit_data, abcd[k]); end
            checks++; if (flit_index !== CW'(k)) begin errors++; $display("FAIL basic_index[%0d] got %0d want %0d", k, flit_index, k); end
            checks++; if (flit_last !== (k == 3)) begin errors++; $display("FAIL basic_last[%0d] got %b want %b", k, flit_last, (k == 3)); end
            tick();
        end
        checks++; if (flit_valid !== 1'b0) begin errors++; $display("FAIL basic_hold_valid got %b want 0", flit_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_hold_busy got %b want 0", busy); end
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL basic_hold_ready got %b want 1", load_ready); end
        $display("basic: 4-chunk payload sent");
    endtask

    task automatic test_stall();
        logic pat [12] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        int k = 0;
        int c = 0;
        flit_ready = 1'b1;
        do_load(abcd_payload, 3'd4);
        while (k < 4 && c < 12) begin
            flit_ready = pat[c];
            checks++; if (flit_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[c%0d] got %b want 1", c, flit_valid); end
            checks++; if (flit_data !== abcd[k]) begin errors++; $display("FAIL stall_data[c%0d] got %h want %h", c, flit_data, abcd[k]); end
            checks++; if (flit_index !== CW'(k)) begin errors++; $display("FAIL stall_index[c%0d] got %0d want %0d", c, flit_index, k); end
            if (pat[c]) k++;
            c++;
            tick();
        end
        flit_ready = 1'b1;
        checks++; if (k !== 4) begin errors++; $display("FAIL stall_timeout got %0d chunks want 4", k); end
        checks++; if (flit_valid !== 1'b0) begin errors++; $display("FAIL stall_end_valid got %b want 0", flit_valid); end
        $display("stall: chunks held during backpressure");
    endtask

    task automatic test_resend_hold();
        logic [BW-1:0] ef [2];
        logic [PW-1:0] efp;
        ef[0] = 30'h0E;
        ef[1] = 30'h0F;
        efp   = {30'h0, 30'h0, ef[1], ef[0]};
        flit_ready = 1'b1;
        resend = 1'b1;
        tick();
        resend = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++; if (flit_valid !== 1'b1 || flit_data !== abcd[k]) begin errors++; $display("FAIL resend_hold[%0d] got v=%b d=%h want v=1 d=%h", k, flit_valid, flit_data, abcd[k]); end
            tick();
        end
        checks++; if (flit_valid !== 1'b0) begin errors++; $display("FAIL resend_hold_end got %b want 0", flit_valid); end
        resend = 1'b1;
        do_load(efp, 3'd2);
        resend = 1'b0;
        for (int k = 0; k < 2; k++) begin
            checks++; if (flit_valid !== 1'b1 || flit_data !== ef[k] || flit_last !== (k == 1)) begin errors++; $display("FAIL load_over_resend[%0d] got v=%b d=%h l=%b want v=1 d=%h l=%b", k, flit_valid, flit_data, flit_last, ef[k], (k == 1)); end
            tick();
        end
        checks++; if (flit_valid !== 1'b0) begin errors++; $display("FAIL load_over_resend_end got %b want 0", flit_valid); end
        $display("resend_hold: replay and load-priority checked");
    endtask

    task automatic test_resend_send();
        flit_ready = 1'b1;
        do_load(abcd_payload, 3'd4);
        tick();
        tick();
        checks++; if (flit_index !== 3'd2) begin errors++; $display("FAIL resend_send_pre got idx %0d want 2", flit_index); end
        resend = 1'b1;
        tick();
        resend = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++; if (flit_valid !== 1'b1 || flit_data !== abcd[k] || flit_index !== CW'(k)) begin errors++; $display("FAIL resend_send[%0d] got v=%b d=%h i=%0d want v=1 d=%h i=%0d", k, flit_valid, flit_data, flit_index, abcd[k], k); end
            tick();
        end
        checks++; if (flit_valid !== 1'b0) begin errors++; $display("FAIL resend_send_end got %b want 0", flit_valid); end
        $display("resend_send: restart mid-transfer");
    endtask

    task automatic test_nflits();
        flit_ready = 1'b1;
        do_load({90'h0, 30'h15}, 3'd1);
        checks++; if (flit_valid !== 1'b1 || flit_data !== 30'h15 || flit_last !== 1'b1) begin errors++; $display("FAIL single got v=%b d=%h l=%b want v=1 d=15 l=1", flit_valid, flit_data, flit_last); end
        tick();
        checks++; if (flit_valid !== 1'b0) begin errors++; $display("FAIL single_end got %b want 0", flit_valid); end
        do_load(abcd_payload, 3'd7);
        for (int k = 0; k < 4; k++) begin
            checks++; if (flit_valid !== 1'b1 || flit_data !== abcd[k] || flit_last !== (k == 3)) begin errors++; $display("FAIL clamp[%0d] got v=%b d=%h l=%b want v=1 d=%h l=%b", k, flit_valid, flit_data, flit_last, abcd[k], (k == 3)); end
            tick();
        end
        checks++; if (flit_valid !== 1'b0) begin errors++; $display("FAIL clamp_end got %b want 0", flit_valid); end
        do_load({4{30'h3FFFFFFF}}, 3'd0);
        checks++; if (flit_valid !== 1'b0 || busy !== 1'b0 || load_ready !== 1'b1) begin errors++; $display("FAIL zero_load got v=%b b=%b r=%b want 0 0 1", flit_valid, busy, load_ready); end
        resend = 1'b1;
        tick();
        resend = 1'b0;
        checks++; if (flit_valid !== 1'b1 || flit_data !== abcd[0]) begin errors++; $display("FAIL zero_load_retained got v=%b d=%h want v=1 d=%h", flit_valid, flit_data, abcd[0]); end
        for (int k = 0; k < 4; k++) tick();
        $display("nflits: single, clamp and zero-length checked");
    endtask

    task automatic test_reset_mid();
        flit_ready = 1'b1;
        do_load(abcd_payload, 3'd4);
        tick();
        checks++; if (flit_index !== 3'd1) begin errors++; $display("FAIL reset_mid_pre got idx %0d want 1", flit_index); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (flit_valid !== 1'b0 || flit_data !== '0 || flit_last !== 1'b0 || flit_index !== '0 || busy !== 1'b0) begin errors++; $display("FAIL reset_mid got v=%b d=%h l=%b i=%0d b=%b want all 0", flit_valid, flit_data, flit_last, flit_index, busy); end
        resend = 1'b1;
        tick();
        resend = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checks++; if (flit_valid !== 1'b0) begin errors++; $display("FAIL resend_after_reset[%0d] got %b want 0", c, flit_valid); end
            tick();
        end
        $display("reset_mid: transfer aborted, no replay");
    endtask

    initial begin
        for (int k = 0; k < 4; k++) abcd[k] = BW'(32'hA + k);
        abcd_payload = {abcd[3], abcd[2], abcd[1], abcd[0]};
        reset        = 1'b1;
        load_valid   = 1'b0;
        load_payload = '0;
        load_nflits  = '0;
        resend       = 1'b0;
        flit_ready   = 1'b0;
        #1;
        test_reset();
        test_basic();
        test_stall();
        test_resend_hold();
        test_resend_send();
        test_nflits();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
